cert_chain_ctrl: RTL

Parametrised successor to the single-chain certificate controller in the authentication initiator. Walks a certificate chain of up to MAX_CERTS entries for a selected slot. For each entry it issues a GET_CERTIFICATE request, waits for the response with a timeout, validates the header, and hands the payload to an external comparator. It adds per-request timeout, bounded retry, abort, and a coded failure reason, and reports done/failed to the authentication top level.

---
 rtl/cert_chain_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/cert_chain_ctrl.sv
// Certificate chain walker: issues one GET_CERTIFICATE per chain entry, checks each response
// header, hands the payload to an external comparator, and reports done/failed with a reason code.
module cert_chain_ctrl #(
  parameter int unsigned PAYLOAD_W   = 256,
  parameter int unsigned SLOT_W      = 2,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned MAX_CERTS   = 8,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [SLOT_W-1:0]    slot,
  input  logic [CNT_W-1:0]     num_certs,
  output logic                 req_valid,
  input  logic                 req_ready,
  output logic [15:0]          req_header,
  output logic [PAYLOAD_W-1:0] req_payload,
  input  logic                 rsp_valid,
  input  logic [15:0]          rsp_header,
  input  logic [PAYLOAD_W-1:0] rsp_payload,
  output logic                 cmp_start,
  output logic [CNT_W-1:0]     cmp_index,
  output logic [PAYLOAD_W-1:0] cmp_payload,
  input  logic                 cmp_done,
  input  logic                 cmp_pass,
  output logic                 busy,
  output logic                 done,
  output logic                 failed,
  output logic [2:0]           fail_code,
  output logic [CNT_W-1:0]     cert_index
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [15:0] GET_CERT_HDR = 16'h0181;
  localparam logic [15:0] CERT_RSP_HDR = 16'h0102;

  localparam logic [2:0] FC_BAD_COUNT = 3'd1;
  localparam logic [2:0] FC_TIMEOUT   = 3'd2;
  localparam logic [2:0] FC_BAD_HDR   = 3'd3;
  localparam logic [2:0] FC_CMP_FAIL  = 3'd4;
  localparam logic [2:0] FC_ABORT     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_RSP, S_CMP, S_NEXT, S_DONE, S_FAIL
  } state_t;

  state_t            state;
  logic [SLOT_W-1:0] slot_q;
  logic [CNT_W-1:0]  num_q;
  logic [TMR_W-1:0]  timer;
  logic [RTY_W-1:0]  retry;

  // The comparator always works on the certificate currently being walked.
  assign cmp_index = cert_index;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      slot_q      <= '0;
      num_q       <= '0;
      timer       <= '0;
      retry       <= '0;
      req_valid   <= 1'b0;
      req_header  <= '0;
      req_payload <= '0;
      cmp_start   <= 1'b0;
      cmp_payload <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      failed      <= 1'b0;
      fail_code   <= '0;
      cert_index  <= '0;
    end else begin
      cmp_start <= 1'b0;
      if (abort && (state inside {S_REQ, S_WAIT_RSP, S_CMP, S_NEXT})) begin
        state     <= S_FAIL;
        req_valid <= 1'b0;
        busy      <= 1'b0;
        failed    <= 1'b1;
        fail_code <= FC_ABORT;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
              slot_q     <= slot;
              num_q      <= num_certs;
              done       <= 1'b0;
              failed     <= 1'b0;
              fail_code  <= '0;
              cert_index <= '0;
              retry      <= '0;
              req_header <= GET_CERT_HDR;
              if ((num_certs == '0) || (num_certs > CNT_W'(MAX_CERTS))) begin
                state     <= S_FAIL;
                failed    <= 1'b1;
                fail_code <= FC_BAD_COUNT;
              end else begin
                state       <= S_REQ;
                req_valid   <= 1'b1;
                busy        <= 1'b1;
                req_payload <= PAYLOAD_W'({slot, CNT_W'(0)});
              end
            end
          end
          S_REQ: begin
            if (req_ready) begin
              state     <= S_WAIT_RSP;
              req_valid <= 1'b0;
              timer     <= '0;
            end
          end
          S_WAIT_RSP: begin
            // A response landing on the timeout cycle still counts.
            if (rsp_valid) begin
              if (rsp_header == CERT_RSP_HDR) begin
                state       <= S_CMP;
                cmp_payload <= rsp_payload;
                cmp_start   <= 1'b1;
              end else begin
                state     <= S_FAIL;
                busy      <= 1'b0;
                failed    <= 1'b1;
                fail_code <= FC_BAD_HDR;
              end
            end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
              if (retry < RTY_W'(MAX_RETRY)) begin
                state     <= S_REQ;
                retry     <= retry + RTY_W'(1);
                req_valid <= 1'b1;
              end else begin
                state     <= S_FAIL;
                busy      <= 1'b0;
                failed    <= 1'b1;
                fail_code <= FC_TIMEOUT;
              end
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          S_CMP: begin
            if (cmp_done) begin
              if (cmp_pass) begin
                state <= S_NEXT;
              end else begin
                state     <= S_FAIL;
                busy      <= 1'b0;
                failed    <= 1'b1;
                fail_code <= FC_CMP_FAIL;
              end
            end
          end
          S_NEXT: begin
            if (cert_index == num_q - CNT_W'(1)) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state       <= S_REQ;
              cert_index  <= cert_index + CNT_W'(1);
              retry       <= '0;
              req_valid   <= 1'b1;
              req_payload <= PAYLOAD_W'({slot_q, cert_index + CNT_W'(1)});
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
